// File: rtl/des_key_scheduler.sv
// DES key schedule: issues the 16 round subkeys in encrypt or decrypt order,
// one per cycle, under a valid/advance handshake with the round datapath.
module des_key_scheduler (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_decrypt,
    input  logic [63:0] i_key,
    input  logic        i_advance,
    output logic [47:0] o_subkey,
    output logic        o_subkey_valid,
    output logic [3:0]  o_round,
    output logic        o_busy,
    output logic        o_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Table entries are 1-based FIPS bit numbers; vector index = bit number - 1.
    localparam logic [5:0] PC1_TBL [56] = '{
        6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
        6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
        6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
        6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
        6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
        6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
        6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
        6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
    };

    localparam logic [5:0] PC2_TBL [48] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    localparam logic [1:0] SHIFT_TBL [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    function automatic logic [55:0] pc1(input logic [63:0] key);
        logic [55:0] cd;
        cd = 56'd0;
        for (int j = 0; j < 56; j++) begin
            cd[j] = key[PC1_TBL[j] - 6'd1];
        end
        return cd;
    endfunction

    function automatic logic [47:0] pc2(input logic [27:0] c, input logic [27:0] d);
        logic [55:0] cd;
        logic [47:0] sub;
        cd  = {d, c};
        sub = 48'd0;
        for (int j = 0; j < 48; j++) begin
            sub[j] = cd[PC2_TBL[j] - 6'd1];
        end
        return sub;
    endfunction

    // A FIPS left rotation moves bits toward index 0.
    function automatic logic [27:0] rotl(input logic [27:0] v, input logic [1:0] amt);
        if (amt == 2'd2) begin
            return {v[1:0], v[27:2]};
        end else begin
            return {v[0], v[27:1]};
        end
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] v, input logic [1:0] amt);
        if (amt == 2'd2) begin
            return {v[25:0], v[27:26]};
        end else begin
            return {v[26:0], v[27]};
        end
    endfunction

    state_t      state_q, state_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic [3:0]  step_q, step_d;
    logic        dec_q, dec_d;
    logic [55:0] key_cd_s;

    assign key_cd_s = pc1(i_key);

    // State and schedule registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            c_q     <= 28'd0;
            d_q     <= 28'd0;
            step_q  <= 4'd0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            step_q  <= step_d;
            dec_q   <= dec_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_ROUND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ROUND: begin
                if (i_advance && (step_q == 4'd15)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ROUND;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Decrypt loads the unrotated C0,D0, which equals C16,D16 since the shifts total 28
    always_comb begin
        c_d    = c_q;
        d_d    = d_q;
        step_d = step_q;
        dec_d  = dec_q;
        if ((state_q == ST_IDLE) && i_start) begin
            dec_d  = i_decrypt;
            step_d = 4'd0;
            if (i_decrypt) begin
                c_d = key_cd_s[27:0];
                d_d = key_cd_s[55:28];
            end else begin
                c_d = rotl(key_cd_s[27:0], 2'd1);
                d_d = rotl(key_cd_s[55:28], 2'd1);
            end
        end else if ((state_q == ST_ROUND) && i_advance) begin
            if (step_q == 4'd15) begin
                step_d = 4'd0;
            end else if (dec_q) begin
                step_d = step_q + 4'd1;
                c_d    = rotr(c_q, SHIFT_TBL[4'd15 - step_q]);
                d_d    = rotr(d_q, SHIFT_TBL[4'd15 - step_q]);
            end else begin
                step_d = step_q + 4'd1;
                c_d    = rotl(c_q, SHIFT_TBL[step_q + 4'd1]);
                d_d    = rotl(d_q, SHIFT_TBL[step_q + 4'd1]);
            end
        end else begin
            step_d = step_q;
        end
    end

    // Output decode
    always_comb begin
        o_subkey       = 48'd0;
        o_subkey_valid = 1'b0;
        o_round        = 4'd0;
        o_busy         = 1'b0;
        o_done         = 1'b0;
        case (state_q)
            ST_IDLE: o_busy = 1'b0;
            ST_ROUND: begin
                o_subkey       = pc2(c_q, d_q);
                o_subkey_valid = 1'b1;
                o_round        = step_q;
                o_busy         = 1'b1;
            end
            ST_DONE: begin
                o_busy = 1'b1;
                o_done = 1'b1;
            end
            default: o_busy = 1'b0;
        endcase
    end

endmodule
